// File: rtl/tff_bank_arbiter.sv
// rtl/tff_bank_arbiter.sv - round-robin arbiter sharing one bank of T flip-flops
// Grants one requester at a time and XORs its mask into the bank, then optionally cools down.
module tff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mask,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      t_vec,
    output logic [WIDTH-1:0]      Q,
    output logic [WIDTH-1:0]      Q_bar,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_COOL = 1'b1;

    logic              r_state;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic [WIDTH-1:0]  r_tvec;
    logic [WIDTH-1:0]  r_q;

    logic [NREQ-1:0]   w_eff;
    logic [PW-1:0]     w_win;
    logic              w_found;
    logic [WIDTH-1:0]  w_mask;
    logic [PW-1:0]     w_ptr_next;
    logic [NREQ-1:0]   w_onehot;
    int                w_idx;

    // A requester being granted this cycle is already served; its held req must not win again.
    assign w_eff = req & ~r_gnt;

    // Scan downward so the last hit is the one closest to r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (w_eff[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    assign w_mask     = mask[int'(w_win)*WIDTH +: WIDTH];
    assign w_ptr_next = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_tvec  <= '0;
            r_q     <= '0;
        end else begin
            r_gnt  <= '0;
            r_tvec <= '0;
            case (r_state)
                S_IDLE: begin
                    if (en && w_found) begin
                        r_gnt  <= w_onehot;
                        r_tvec <= w_mask;
                        r_q    <= r_q ^ w_mask;
                        r_ptr  <= w_ptr_next;
                        if (GAP > 0) begin
                            r_state <= S_COOL;
                            r_cnt   <= CW'(GAP);
                        end
                    end
                end
                S_COOL: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign t_vec = r_tvec;
    assign Q     = r_q;
    assign Q_bar = ~r_q;
    assign busy  = (r_state == S_COOL);

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// tb/tb_tff_bank_arbiter.sv - scoreboard bench for tff_bank_arbiter (GAP=2 and GAP=0 instances)
module tb_tff_bank_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] mask;

    logic [3:0]  a_gnt, b_gnt;
    logic [7:0]  a_tv, b_tv, a_q, b_q, a_qb, b_qb;
    logic        a_busy, b_busy;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0] req;
        logic       en;
        logic [3:0] gnt;
        logic [7:0] q;
        logic [7:0] tv;
        logic       busy;
    } entry_t;

    entry_t sb[$];

    tff_bank_arbiter #(.NREQ(4), .WIDTH(8), .GAP(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask),
        .gnt(a_gnt), .t_vec(a_tv), .Q(a_q), .Q_bar(a_qb), .busy(a_busy)
    );

    tff_bank_arbiter #(.NREQ(4), .WIDTH(8), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask),
        .gnt(b_gnt), .t_vec(b_tv), .Q(b_q), .Q_bar(b_qb), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            n_checks++;
            if (a_qb !== ~a_q || b_qb !== ~b_q) begin
                n_err++;
                $display("FAIL qbar: got a=%h/%h b=%h/%h want complements", a_q, a_qb, b_q, b_qb);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req  = '0;
        en   = 1'b0;
        mask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req  = 4'($urandom);
            mask = $urandom;
            step();
            n_checks++;
            if (a_q !== 8'h00 || a_qb !== 8'hFF || a_gnt !== 4'h0 || a_busy !== 1'b0 || a_tv !== 8'h00) begin
                n_err++;
                $display("FAIL reset_a: got q=%h qb=%h gnt=%b busy=%b tv=%h want 00 ff 0000 0 00",
                         a_q, a_qb, a_gnt, a_busy, a_tv);
            end
            n_checks++;
            if (b_q !== 8'h00 || b_qb !== 8'hFF || b_gnt !== 4'h0 || b_busy !== 1'b0 || b_tv !== 8'h00) begin
                n_err++;
                $display("FAIL reset_b: got q=%h qb=%h gnt=%b busy=%b tv=%h want 00 ff 0000 0 00",
                         b_q, b_qb, b_gnt, b_busy, b_tv);
            end
        end
    endtask

    task automatic test_single();
        entry_t e;
        do_reset();
        mask = {8'h00, 8'h00, 8'h00, 8'hA5};
        sb.push_back('{4'b0001, 1'b1, 4'b0001, 8'hA5, 8'hA5, 1'b1});
        sb.push_back('{4'b0001, 1'b1, 4'b0000, 8'hA5, 8'h00, 1'b1});
        sb.push_back('{4'b0001, 1'b1, 4'b0000, 8'hA5, 8'h00, 1'b0});
        sb.push_back('{4'b0001, 1'b1, 4'b0001, 8'h00, 8'hA5, 1'b1});
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            req = e.req;
            en  = e.en;
            step();
            n_checks++;
            if (a_gnt !== e.gnt || a_q !== e.q || a_tv !== e.tv || a_busy !== e.busy) begin
                n_err++;
                $display("FAIL single: got gnt=%b q=%h tv=%h busy=%b want gnt=%b q=%h tv=%h busy=%b",
                         a_gnt, a_q, a_tv, a_busy, e.gnt, e.q, e.tv, e.busy);
            end
        end
    endtask

    task automatic test_round_robin();
        entry_t e;
        do_reset();
        mask = {8'h08, 8'h04, 8'h02, 8'h01};
        sb.push_back('{4'b1111, 1'b1, 4'b0001, 8'h01, 8'h01, 1'b0});
        sb.push_back('{4'b1111, 1'b1, 4'b0010, 8'h03, 8'h02, 1'b0});
        sb.push_back('{4'b1111, 1'b1, 4'b0100, 8'h07, 8'h04, 1'b0});
        sb.push_back('{4'b1111, 1'b1, 4'b1000, 8'h0F, 8'h08, 1'b0});
        sb.push_back('{4'b1111, 1'b1, 4'b0001, 8'h0E, 8'h01, 1'b0});
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            req = e.req;
            en  = e.en;
            step();
            n_checks++;
            if (b_gnt !== e.gnt || b_q !== e.q || b_tv !== e.tv || b_busy !== e.busy) begin
                n_err++;
                $display("FAIL round_robin: got gnt=%b q=%h tv=%h busy=%b want gnt=%b q=%h tv=%h busy=%b",
                         b_gnt, b_q, b_tv, b_busy, e.gnt, e.q, e.tv, e.busy);
            end
        end
    endtask

    task automatic test_wrap();
        entry_t e;
        do_reset();
        mask = {8'h08, 8'h04, 8'h02, 8'h01};
        sb.push_back('{4'b0100, 1'b1, 4'b0100, 8'h04, 8'h04, 1'b0});
        sb.push_back('{4'b0101, 1'b1, 4'b0001, 8'h05, 8'h01, 1'b0});
        sb.push_back('{4'b0101, 1'b1, 4'b0100, 8'h01, 8'h04, 1'b0});
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            req = e.req;
            en  = e.en;
            step();
            n_checks++;
            if (b_gnt !== e.gnt || b_q !== e.q || b_tv !== e.tv || b_busy !== e.busy) begin
                n_err++;
                $display("FAIL wrap: got gnt=%b q=%h tv=%h busy=%b want gnt=%b q=%h tv=%h busy=%b",
                         b_gnt, b_q, b_tv, b_busy, e.gnt, e.q, e.tv, e.busy);
            end
        end
    endtask

    task automatic test_enable_cooldown();
        entry_t e;
        do_reset();
        mask = {8'h00, 8'h00, 8'h3C, 8'h00};
        for (int i = 0; i < 5; i++)
            sb.push_back('{4'b0010, 1'b0, 4'b0000, 8'h00, 8'h00, 1'b0});
        sb.push_back('{4'b0010, 1'b1, 4'b0010, 8'h3C, 8'h3C, 1'b1});
        sb.push_back('{4'b0000, 1'b0, 4'b0000, 8'h3C, 8'h00, 1'b1});
        sb.push_back('{4'b0000, 1'b0, 4'b0000, 8'h3C, 8'h00, 1'b0});
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            req = e.req;
            en  = e.en;
            step();
            n_checks++;
            if (a_gnt !== e.gnt || a_q !== e.q || a_tv !== e.tv || a_busy !== e.busy) begin
                n_err++;
                $display("FAIL enable_cooldown: got gnt=%b q=%h tv=%h busy=%b want gnt=%b q=%h tv=%h busy=%b",
                         a_gnt, a_q, a_tv, a_busy, e.gnt, e.q, e.tv, e.busy);
            end
        end
    endtask

    task automatic test_edge_cases();
        entry_t e;
        do_reset();
        mask = {8'h00, 8'h00, 8'h11, 8'h00};
        // zero mask grant, then ptr must favour requester 1 over requester 0
        sb.push_back('{4'b0001, 1'b1, 4'b0001, 8'h00, 8'h00, 1'b1});
        sb.push_back('{4'b0000, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b1});
        sb.push_back('{4'b0000, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b0});
        sb.push_back('{4'b0011, 1'b1, 4'b0010, 8'h11, 8'h11, 1'b1});
        // requests dropped during cooldown never produce a grant
        sb.push_back('{4'b0001, 1'b1, 4'b0000, 8'h11, 8'h00, 1'b1});
        sb.push_back('{4'b0000, 1'b1, 4'b0000, 8'h11, 8'h00, 1'b0});
        sb.push_back('{4'b0000, 1'b1, 4'b0000, 8'h11, 8'h00, 1'b0});
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            req = e.req;
            en  = e.en;
            step();
            n_checks++;
            if (a_gnt !== e.gnt || a_q !== e.q || a_tv !== e.tv || a_busy !== e.busy) begin
                n_err++;
                $display("FAIL edge_cases: got gnt=%b q=%h tv=%h busy=%b want gnt=%b q=%h tv=%h busy=%b",
                         a_gnt, a_q, a_tv, a_busy, e.gnt, e.q, e.tv, e.busy);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mask = {8'h00, 8'h00, 8'h00, 8'hA5};
        req  = 4'b0001;
        en   = 1'b1;
        step();
        n_checks++;
        if (a_busy !== 1'b1 || a_q !== 8'hA5) begin
            n_err++;
            $display("FAIL async_pre: got busy=%b q=%h want 1 a5", a_busy, a_q);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_busy !== 1'b0 || a_q !== 8'h00 || a_qb !== 8'hFF || a_gnt !== 4'h0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b q=%h qb=%h gnt=%b want 0 00 ff 0000",
                     a_busy, a_q, a_qb, a_gnt);
        end
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        step();
        n_checks++;
        if (a_gnt !== 4'h0 || a_busy !== 1'b0 || a_q !== 8'h00) begin
            n_err++;
            $display("FAIL async_after: got gnt=%b busy=%b q=%h want 0000 0 00", a_gnt, a_busy, a_q);
        end
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        req  = '0;
        mask = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_enable_cooldown();
        test_edge_cases();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tff_bank_arbiter.md
Name: tff_bank_arbiter

Overview:
Round-robin arbiter and sequencer that shares one register bank of WIDTH toggle (T-type) flip-flops among NREQ requesters. Each requester presents a toggle mask. The block grants one requester at a time and applies that mask as the T inputs of the bank. A programmable cooldown sequences successive toggles. It sits between control agents and the shared toggle-register resource; Q/Q_bar are the bank outputs.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, number of T flip-flops in the bank
GAP, 2, idle cycles enforced after each grant (0 = back-to-back grants allowed)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  global grant enable; 0 blocks new grants
req  input  NREQ  per-requester toggle request, level, held until granted
mask  input  NREQ*WIDTH  requester i mask at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot grant pulse, one cycle
t_vec  output  WIDTH  registered T vector applied at last grant (0 otherwise)
Q  output  WIDTH  toggle bank state
Q_bar  output  WIDTH  bitwise complement of Q
busy  output  1  high while in COOLDOWN

Behaviour:
- Reset (rst=0, async): Q=0, Q_bar=all ones, gnt=0, t_vec=0, busy=0, priority pointer ptr=0, state=IDLE, cooldown counter=0. Takes effect immediately, independent of clk.
- Reset mid-operation: any COOLDOWN or pending grant is abandoned. After release, the first edge evaluates from IDLE with ptr=0.
- States: IDLE, COOLDOWN.
- Effective request: eff = req with bit i cleared when gnt[i]=1 in the current cycle. A request seen during its own grant cycle is treated as consumed.
- Winner: the first set bit of eff, searching from ptr upward with wrap NREQ-1 -> 0.
- IDLE, edge with en=1 and eff!=0:
  - gnt <= onehot(winner)
  - t_vec <= mask[winner]
  - Q <= Q ^ mask[winner]
  - ptr <= (winner+1) mod NREQ
  - If GAP>0: state <= COOLDOWN, count <= GAP. Otherwise stay IDLE.
- IDLE, edge with en=0 or eff=0: gnt <= 0, t_vec <= 0, Q holds, ptr holds.
- COOLDOWN: gnt <= 0, t_vec <= 0, count decrements each edge. When count=1, state <= IDLE on that edge. busy=1 for exactly GAP cycles. en has no effect on the countdown.
- Grant latency: the grant appears on the first edge after req is seen in IDLE, so gnt and the Q update are visible 1 cycle after the sampled req.
- Throughput:
  - GAP=0: one grant per cycle; the same requester can win at most every other cycle.
  - GAP>0: one grant per GAP+1 cycles.
- Zero mask: the grant is still issued and ptr still advances; Q is unchanged and t_vec=0.
- Overlapping masks from different requesters are applied in grant order, so each toggle is cumulative (XOR).
- Dropping req before grant is legal; nothing is issued for that requester.
- Q_bar = ~Q combinationally; it is never equal to Q at any bit.
- mask is sampled only on the grant edge; changing it at other times has no effect.

Test Plan:
- Reset: hold rst=0 with random req/mask -> Q=8'h00, Q_bar=8'hFF, gnt=0, busy=0. Assert rst=0 asynchronously mid-COOLDOWN -> busy drops immediately, Q=0.
- Single requester: req=4'b0001, mask0=8'hA5, GAP=2 -> gnt=0001 for 1 cycle, Q=8'hA5, t_vec=8'hA5, busy=1 for 2 cycles. Hold req -> second grant 3 cycles later, Q=8'h00.
- Round-robin fairness: req=4'b1111, masks 01/02/04/08, GAP=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, Q=8'h01, 03, 07, 0F, 0E.
- Pointer wrap: ptr=3 after granting req2, req=4'b0101 -> next gnt=0001 (wrap), then 0100.
- Enable and cooldown interaction: en=0 with req=4'b0010 -> no gnt for 5 cycles. en=1 -> gnt=0010 next edge. Raise en=0 during COOLDOWN -> busy still lasts exactly GAP cycles.
- Edge cases: mask=8'h00 -> gnt pulses, Q unchanged, ptr advances. Drop req before IDLE -> no gnt. Q_bar==~Q checked every cycle.
